// File: rtl/avalon_mem_pkg.sv
// Shared types, widths and the byte-lane merge helper for the Avalon-MM word memory.
package avalon_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [WORD_W-1:0] be_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_word_array.sv
// Word storage: byte-enabled bus write port, full-word preload port, registered read port.
module ram_word_array
  import avalon_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  wr_en,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic [BE_W-1:0]       be,
  input  logic                  rd_en,
  output logic [WORD_W-1:0]     rd_data,
  input  logic                  pl_en,
  input  logic [DEPTH_LOG2-1:0] pl_addr,
  input  logic [WORD_W-1:0]     pl_data
);

  logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Preload is written last so it overrides a bus write to the same word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= be_merge(mem[addr], wr_data, be);
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/avalon_ram_slave.sv
// Avalon-MM slave word memory with programmable wait states and a side-band preload port.
// Handshake: a transfer completes in the cycle where (read|write)=1 and waitrequest=0;
// the master holds address/data/byteenable stable while waitrequest=1.
module avalon_ram_slave
  import avalon_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  output logic              waitrequest,
  input  logic [WORD_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic [WORD_W-1:0] readdata,
  input  logic              inst_input,
  input  logic [7:0]        inst_addr,
  input  logic [WORD_W-1:0] instruction,
  output logic              protocol_err
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       req;
  logic       abort;
  logic       rd_en;
  logic       wr_en;
  logic       unused_addr_bits;

  assign req = read | write;
  assign unused_addr_bits = ^{address[31:DEPTH_LOG2+2], address[1:0], inst_addr[1:0]};

  // Preload holds the FSM in IDLE and stalls any request until it drops.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    waitrequest = 1'b0;
    abort       = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    if (inst_input) begin
      state_nxt   = IDLE;
      waitrequest = req;
    end else begin
      case (state)
        IDLE: begin
          waitrequest = req;
          if (req) begin
            cnt_nxt = CNT_INIT;
            if (CNT_INIT == 4'd0) begin
              state_nxt = ACK;
              rd_en     = read & ~write;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          waitrequest = 1'b1;
          if (!req) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            abort     = 1'b1;
          end else begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
              state_nxt = ACK;
              rd_en     = read & ~write;
            end
          end
        end
        ACK: begin
          state_nxt = IDLE;
          wr_en     = write;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (abort || (read && write)) protocol_err <= 1'b1;
    end
  end

  ram_word_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .addr    (address[DEPTH_LOG2+1:2]),
    .wr_en   (wr_en),
    .wr_data (writedata),
    .be      (byteenable),
    .rd_en   (rd_en),
    .rd_data (readdata),
    .pl_en   (inst_input),
    .pl_addr (DEPTH_LOG2'(inst_addr[7:2])),
    .pl_data (instruction)
  );

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Directed bench for avalon_ram_slave: one instance with 2 wait states, one with 1.
module tb_avalon_ram_slave;

  localparam int WC_A = 2;

  logic        clk;
  logic        reset;
  logic [31:0] address, writedata, readdata, instruction;
  logic        read, write, waitrequest, inst_input, protocol_err;
  logic [3:0]  byteenable;
  logic [7:0]  inst_addr;

  logic [31:0] b_address, b_writedata, b_readdata, b_instruction;
  logic        b_read, b_write, b_waitrequest, b_inst_input, b_protocol_err;
  logic [3:0]  b_byteenable;
  logic [7:0]  b_inst_addr;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stalls;
  logic [31:0] rdata;

  avalon_ram_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(WC_A)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .inst_input(inst_input), .inst_addr(inst_addr),
    .instruction(instruction), .protocol_err(protocol_err)
  );

  avalon_ram_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .address(b_address), .read(b_read), .write(b_write),
    .waitrequest(b_waitrequest), .writedata(b_writedata), .byteenable(b_byteenable),
    .readdata(b_readdata), .inst_input(b_inst_input), .inst_addr(b_inst_addr),
    .instruction(b_instruction), .protocol_err(b_protocol_err)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic preload(input bit sel, input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    if (sel) begin
      b_inst_input = 1'b1; b_inst_addr = a; b_instruction = d;
    end else begin
      inst_input = 1'b1; inst_addr = a; instruction = d;
    end
    @(posedge clk); #1;
    inst_input   = 1'b0;
    b_inst_input = 1'b0;
  endtask

  task automatic wait_ack(output int n, output logic [31:0] rd);
    n = 0;
    @(negedge clk);
    while (waitrequest === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    rd = readdata;
    @(posedge clk); #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          output int n, output logic [31:0] rdv);
    @(posedge clk); #1;
    address = a; read = rd; write = wr; writedata = d; byteenable = be;
    wait_ack(n, rdv);
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int          n;
    logic [31:0] rdv;
    exp_q.push_back(exp);
    bus_xfer(1'b1, 1'b0, a, 32'h0, 4'h0, n, rdv);
    check({tag, "_stalls"}, n, WC_A);
    check(tag, rdv, exp_q.pop_front());
  endtask

  task automatic abort_xfer(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d);
    @(posedge clk); #1;
    address = a; read = rd; write = wr; writedata = d; byteenable = 4'hF;
    @(posedge clk); #1;
    read  = 1'b0;
    write = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed sequence
  initial begin
    reset = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
    inst_input = 1'b0; inst_addr = '0; instruction = '0;
    b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0; b_byteenable = '0;
    b_inst_input = 1'b0; b_inst_addr = '0; b_instruction = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_waitrequest", waitrequest, 1'b0);
    check("rst_protocol_err", protocol_err, 1'b0);
    check("rst_b_readdata", b_readdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Preloaded word read back after two wait states
    preload(1'b0, 8'h04, 32'h24020090);
    bus_read("t1_read", 32'h04, 32'h24020090);
    check("t1_perr", protocol_err, 1'b0);

    // Byte-enabled write merge, plus aliasing and ignored low address bits
    preload(1'b0, 8'h10, 32'h11223344);
    bus_xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0101, stalls, rdata);
    check("t2_wr_stalls", stalls, WC_A);
    bus_read("t2_read", 32'h10, 32'h11AD33EF);
    bus_read("t2_alias", 32'h0000_1012, 32'h11AD33EF);

    // read and write together: behaves as write, flags protocol error
    bus_xfer(1'b1, 1'b1, 32'h20, 32'h00000040, 4'hF, stalls, rdata);
    check("t3_stalls", stalls, WC_A);
    check("t3_rdata_held", rdata, 32'h11AD33EF);
    check("t3_perr", protocol_err, 1'b1);
    bus_read("t3_read", 32'h20, 32'h00000040);
    check("t3_perr_sticky", protocol_err, 1'b1);

    // Preload active while a read is pending
    @(posedge clk); #1;
    address = 32'h04; read = 1'b1;
    inst_input = 1'b1; inst_addr = 8'h30; instruction = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_pl_stall", waitrequest, 1'b1);
      @(posedge clk); #1;
    end
    inst_input = 1'b0;
    wait_ack(stalls, rdata);
    check("t4_stalls", stalls, WC_A);
    check("t4_rdata", rdata, 32'h24020090);
    bus_read("t4_pl_word", 32'h30, 32'hCAFEF00D);
    check("t4_perr_sticky", protocol_err, 1'b1);

    // Reset during the WAIT phase of a write
    preload(1'b0, 8'h08, 32'h0BADF00D);
    @(posedge clk); #1;
    address = 32'h08; write = 1'b1; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    write = 1'b0;
    @(negedge clk);
    check("t5_in_rst_rdata", readdata, 32'h0);
    check("t5_in_rst_perr", protocol_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_post_wr", waitrequest, 1'b0);
    check("t5_post_rdata", readdata, 32'h0);
    check("t5_post_perr", protocol_err, 1'b0);
    bus_read("t5_word", 32'h08, 32'h0BADF00D);
    check("t5_perr_clear", protocol_err, 1'b0);

    // Request dropped during WAIT: abort, no side effects, sticky error
    abort_xfer(1'b1, 1'b0, 32'h10, 32'h0);
    check("ab_rd_perr", protocol_err, 1'b1);
    check("ab_rd_wr", waitrequest, 1'b0);
    check("ab_rd_rdata", readdata, 32'h0BADF00D);
    abort_xfer(1'b0, 1'b1, 32'h04, 32'h0);
    bus_read("ab_wr_word", 32'h04, 32'h24020090);

    // Single wait state, back-to-back reads
    preload(1'b1, 8'h04, 32'hA1A1_0004);
    preload(1'b1, 8'h08, 32'hB2B2_0008);
    preload(1'b1, 8'h0C, 32'hC3C3_000C);
    preload(1'b1, 8'h10, 32'hD4D4_0010);
    exp_q.push_back(32'hA1A1_0004);
    exp_q.push_back(32'hB2B2_0008);
    exp_q.push_back(32'hC3C3_000C);
    exp_q.push_back(32'hD4D4_0010);
    @(posedge clk); #1;
    b_address = 32'h04; b_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_stall", b_waitrequest, 1'b1);
      @(negedge clk);
      check("t6_ack", b_waitrequest, 1'b0);
      check("t6_rdata", b_readdata, exp_q.pop_front());
      @(posedge clk); #1;
      if (i < 3) b_address = b_address + 32'd4;
      else b_read = 1'b0;
    end
    @(negedge clk);
    check("t6_idle", b_waitrequest, 1'b0);
    check("t6_perr", b_protocol_err, 1'b0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
